// File: rtl/conware_row_engine.sv
// conware_row_engine: one Game of Life generation per frame, streamed row by row
// through a three-row window (top/mid plus the incoming row as bot).
module conware_row_engine #(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
);
    localparam int RW = $clog2(HEIGHT + 1);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] EMIT  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    logic [1:0]       state;
    logic [RW-1:0]    rows_in;
    logic [WIDTH-1:0] top, mid, bot, nxt;
    logic [WIDTH+1:0] t, m, b;

    assign in_ready  = state == LOAD;
    assign out_valid = state == EMIT;
    assign bot       = state == FLUSH ? '0 : in_data;

    // Zero padding on both sides models the dead cells beyond the grid edge.
    assign t = {1'b0, top, 1'b0};
    assign m = {1'b0, mid, 1'b0};
    assign b = {1'b0, bot, 1'b0};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [3:0] n;
        assign n = 4'(t[i]) + 4'(t[i+1]) + 4'(t[i+2]) + 4'(m[i]) + 4'(m[i+2])
                 + 4'(b[i]) + 4'(b[i+1]) + 4'(b[i+2]);
        assign nxt[i] = (n == 4'd3) | (m[i+1] & (n == 4'd2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            rows_in  <= '0;
            top      <= '0;
            mid      <= '0;
            out_data <= '0;
            out_last <= 1'b0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    mid <= in_data;
                    if (rows_in == '0) begin
                        top     <= '0;
                        rows_in <= RW'(1);
                    end else begin
                        out_data <= nxt;
                        out_last <= 1'b0;
                        top      <= mid;
                        rows_in  <= rows_in + RW'(1);
                        state    <= EMIT;
                    end
                end
                EMIT: if (out_ready) begin
                    if (out_last) begin
                        rows_in  <= '0;
                        out_last <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        state <= rows_in == RW'(HEIGHT) ? FLUSH : LOAD;
                    end
                end
                FLUSH: begin
                    out_data <= nxt;
                    out_last <= 1'b1;
                    state    <= EMIT;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_conware_row_engine.sv
// tb_conware_row_engine: directed frames checked against a 2-D grid model of
// the Game of Life rules, plus literal expectations for each frame.
module tb_conware_row_engine;
    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         out_last;

    conware_row_engine #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W:0]   sb[$];
    logic [W-1:0] got_q[$];
    int last_out_cyc = 0;
    int xfer_cyc = 0;
    int out_mode = 0;
    int hold = 0;
    int gap;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Whole-grid reference: count live neighbours inside the grid for every cell.
    function automatic void model_push(input logic [W-1:0] g[H], input int count);
        for (int r = 0; r < count; r++) begin
            logic [W-1:0] row = '0;
            for (int c = 0; c < W; c++) begin
                int n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < H &&
                            c + dc >= 0 && c + dc < W && g[r+dr][c+dc])
                            n++;
                row[c] = (n == 3) || (g[r][c] && n == 2);
            end
            sb.push_back({r == H - 1, row});
        end
    endfunction

    initial begin : compare
        logic prev_v = 1'b0, prev_r = 1'b0, prev_l = 1'b0;
        logic [W-1:0] prev_d = '0;
        int prev_x = -100;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                chk("ready_valid_exclusive", 32'(in_ready & out_valid), 0);
                if (out_valid) begin
                    if (sb.size() == 0) begin
                        vec++;
                        bad++;
                        $display("FAIL unexpected_output: got %0h expected none", out_data);
                    end else begin
                        chk("out_data", 32'(out_data), 32'(sb[0][W-1:0]));
                        chk("out_last", 32'(out_last), 32'(sb[0][W]));
                    end
                    if (prev_v && !prev_r) begin
                        chk("hold_data", 32'(out_data), 32'(prev_d));
                        chk("hold_last", 32'(out_last), 32'(prev_l));
                    end
                    if (out_last && !prev_v) chk("last_latency", 32'(cyc - prev_x), 2);
                    if (out_ready) begin
                        if (sb.size() != 0) void'(sb.pop_front());
                        got_q.push_back(out_data);
                        prev_x = cyc;
                        if (out_last) last_out_cyc = cyc;
                    end
                end
                if (in_valid && in_ready) xfer_cyc = cyc;
                prev_v = out_valid;
                prev_r = out_ready;
                prev_d = out_data;
                prev_l = out_last;
            end
        end
    end

    // Downstream: 0 = always ready, 1 = stall 5 cycles per output, 2 = never ready.
    initial begin : sink
        forever begin
            @(posedge clk);
            #1;
            if (out_mode == 0) out_ready = 1'b1;
            else if (out_mode == 2) out_ready = 1'b0;
            else if (out_valid && hold < 5) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = out_valid;
                hold = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] d);
        int t = 0;
        in_data = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) begin
            vec++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [W-1:0] a, b, c, d, input bit first_chk, output int g_out);
        logic [W-1:0] g[H];
        g = '{a, b, c, d};
        model_push(g, H);
        send(a);
        g_out = xfer_cyc - last_out_cyc;
        send(b);
        if (first_chk) chk("first_valid_latency", 32'(out_valid), 1);
        send(c);
        send(d);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            vec++;
            bad++;
            $display("FAIL drain_timeout: %0d outputs pending expected 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_got(input string name, input int off, input logic [W-1:0] e0, e1, e2, e3);
        logic [W-1:0] e[4];
        e = '{e0, e1, e2, e3};
        if (got_q.size() < off + 4) begin
            vec++;
            bad++;
            $display("FAIL %s_count: got %0d outputs expected %0d", name, got_q.size(), off + 4);
        end else begin
            for (int i = 0; i < 4; i++) chk(name, 32'(got_q[off+i]), 32'(e[i]));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_out_last", 32'(out_last), 0);
    endtask

    initial begin : stimulus
        logic [W-1:0] g[H];
        do_reset();

        got_q.delete();
        run_frame(4'h2, 4'h2, 4'h2, 4'h0, 1'b1, gap);
        drain();
        check_got("blinker", 0, 4'h0, 4'h7, 4'h0, 4'h0);

        got_q.delete();
        run_frame(4'h0, 4'h6, 4'h6, 4'h0, 1'b0, gap);
        drain();
        check_got("block", 0, 4'h0, 4'h6, 4'h6, 4'h0);

        got_q.delete();
        run_frame(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, gap);
        drain();
        check_got("edge_no_wrap", 0, 4'h9, 4'h0, 4'h0, 4'h9);

        got_q.delete();
        out_mode = 1;
        run_frame(4'h2, 4'h2, 4'h2, 4'h0, 1'b0, gap);
        drain();
        check_got("backpressure", 0, 4'h0, 4'h7, 4'h0, 4'h0);
        out_mode = 0;

        out_mode = 2;
        g = '{4'h2, 4'h2, 4'h2, 4'h0};
        model_push(g, 1);
        send(4'h2);
        send(4'h2);
        repeat (3) @(posedge clk);
        #1;
        chk("stalled_valid", 32'(out_valid), 1);
        do_reset();
        out_mode = 0;
        got_q.delete();
        run_frame(4'h0, 4'h6, 4'h6, 4'h0, 1'b0, gap);
        drain();
        check_got("post_reset_block", 0, 4'h0, 4'h6, 4'h6, 4'h0);

        got_q.delete();
        run_frame(4'h2, 4'h2, 4'h2, 4'h0, 1'b0, gap);
        run_frame(4'h2, 4'h2, 4'h2, 4'h0, 1'b0, gap);
        chk("b2b_first_accept_gap", 32'(gap), 1);
        drain();
        check_got("b2b_frame0", 0, 4'h0, 4'h7, 4'h0, 4'h0);
        check_got("b2b_frame1", 4, 4'h0, 4'h7, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule
